// File: rtl/switch_sum_arbiter_pkg.sv
// Shared types for the switch-sum arbiter: switch pair, sum and response FSM state.
package switch_pkg;
  localparam int SW_PAIR_W = 2;
  localparam int SUM_W     = 2;

  typedef logic [SW_PAIR_W-1:0] sw_pair_t;
  typedef logic [SUM_W-1:0]     sum_t;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_t;

  // Zero-extended add of the two switch bits; result is 0..2 and cannot overflow.
  function automatic sum_t sw_sum(input sw_pair_t pair);
    return {1'b0, pair[0]} + {1'b0, pair[1]};
  endfunction
endpackage

// File: rtl/switch_sum_arbiter_if.sv
// Request/response bundle between requesters, the arbiter and the consumer.
import switch_pkg::*;

interface switch_sum_arbiter_if #(parameter int N_REQ = 4);
  localparam int ID_W = $clog2(N_REQ);

  // Request k moves when i_req_valid[k] & o_req_ready[k]; the response moves
  // when o_rsp_valid & i_rsp_ready, and rsp fields hold while stalled.
  logic [N_REQ-1:0]   i_req_valid;
  logic [2*N_REQ-1:0] i_req_data;
  logic [N_REQ-1:0]   o_req_ready;
  logic               o_rsp_valid;
  sum_t               o_rsp_data;
  logic [ID_W-1:0]    o_rsp_id;
  logic               i_rsp_ready;
  logic               o_busy;
  rsp_state_t         dbg_state;

  modport slave (
    input  i_req_valid, i_req_data, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_id, o_busy, dbg_state
  );

  modport master (
    output i_req_valid, i_req_data, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_id, o_busy, dbg_state
  );
endinterface

// File: rtl/switch_sum_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic            enable,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_idx
);
  logic found;
  int   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (enable && !found && req[ID_W'(idx)]) begin
        found                = 1'b1;
        gnt[ID_W'(idx)]      = 1'b1;
        gnt_idx              = ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/switch_sum_arbiter.sv
// Round-robin shared switch-sum datapath with a one-entry tagged response register.
import switch_pkg::*;

module switch_sum_arbiter #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  switch_sum_arbiter_if.slave  bus
);
  rsp_state_t      state, next_state;
  logic [ID_W-1:0] rr_ptr;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0] gnt_idx;
  logic            can_accept;
  logic            xfer;
  sw_pair_t        pair;
  sum_t            rsp_data;
  logic [ID_W-1:0] rsp_id;

  // A drain and a refill may share a cycle, so a full slot still accepts when ready.
  assign can_accept = (state == RSP_EMPTY) || bus.i_rsp_ready;
  assign xfer       = |gnt;

  rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_arb (
    .req     (bus.i_req_valid),
    .enable  (can_accept),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    pair = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) pair = pair | bus.i_req_data[2*k +: 2];
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      RSP_EMPTY: if (xfer) next_state = RSP_FULL;
      RSP_FULL:  if (bus.i_rsp_ready && !xfer) next_state = RSP_EMPTY;
      default:   next_state = RSP_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= RSP_EMPTY;
      rr_ptr   <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
    end else begin
      state <= next_state;
      if (xfer) begin
        rsp_data <= sw_sum(pair);
        rsp_id   <= gnt_idx;
        rr_ptr   <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  assign bus.o_req_ready = gnt;
  assign bus.o_rsp_valid = (state == RSP_FULL);
  assign bus.o_rsp_data  = rsp_data;
  assign bus.o_rsp_id    = rsp_id;
  assign bus.o_busy      = (|bus.i_req_valid) || (state == RSP_FULL);
  assign bus.dbg_state   = state;
endmodule

// File: doc/switch_sum_arbiter.md
Name: switch_sum_arbiter

Overview:
- Shares a single registered 2-bit switch-sum datapath between N_REQ requesters, each presenting a 2-bit switch pair.
- A round-robin arbiter grants one requester per cycle. The datapath computes sum = bit0 + bit1 (range 0..2). A one-entry response register holds the result, tagged with the requester id, until the consumer accepts it.
- Sits between the switch input synchronisers and the downstream display/logic consumer.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..16.
- ID_W, $clog2(N_REQ), width of the requester id; derived, do not override.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_req_valid  input  N_REQ  per-requester valid.
- i_req_data  input  2*N_REQ  switch pair of requester k at bits [2k+1:2k].
- o_req_ready  output  N_REQ  one-hot accept; bit k high means requester k is granted this cycle.
- o_rsp_valid  output  1  response register holds a result.
- o_rsp_data  output  2  sum of the granted pair, values 0..2.
- o_rsp_id  output  ID_W  index of the requester that produced the result.
- i_rsp_ready  input  1  consumer accepts the response.
- o_busy  output  1  high while any i_req_valid is high or o_rsp_valid is high.

Behaviour:
- Reset (asynchronous assert, synchronous deassert by system):
  - o_rsp_valid=0, o_rsp_data=0, o_rsp_id=0.
  - Round-robin pointer rr_ptr=0.
  - o_req_ready=0 combinationally while no request is pending.
- Handshakes: request k transfers when i_req_valid[k] & o_req_ready[k]; response transfers when o_rsp_valid & i_rsp_ready.
- Slot-free condition: can_accept = !o_rsp_valid | i_rsp_ready. A simultaneous drain and refill in the same cycle must not drop data or bubble.
- Grant (combinational):
  - If can_accept, grant the first valid requester searching rr_ptr, rr_ptr+1, … wrapping modulo N_REQ.
  - o_req_ready is one-hot or zero; it is zero when !can_accept.
- Latency:
  - A request accepted in cycle t appears on o_rsp_* in cycle t+1.
  - With i_rsp_ready held high, throughput is one result per cycle.
- Arithmetic: o_rsp_data = {1'b0,d[0]} + {1'b0,d[1]} using zero-extended 2-bit add; no overflow is possible.
- Pointer update: on a request transfer, rr_ptr <= grant_idx+1, wrapping from N_REQ-1 to 0. Otherwise rr_ptr holds.
- Response register state machine:
  - EMPTY: a transfer loads data/id -> FULL.
  - FULL: backpressure (i_rsp_ready=0) holds data, id and valid stable -> FULL. Drain with a new transfer reloads -> FULL. Drain without a new transfer -> EMPTY.
- Stability: o_rsp_data and o_rsp_id must not change while o_rsp_valid & !i_rsp_ready.
- i_req_data is sampled only in the transfer cycle. A requester may drop valid without having been granted; no state change results.
- Reset mid-operation: a pending response is discarded, no response is emitted after reset, and rr_ptr restarts at 0.
- Fairness: with all requesters valid and no backpressure, grants cycle 0,1,…,N_REQ-1,0. No requester waits more than N_REQ grants.

Decomposition:
- Package switch_pkg holds:
  - SW_PAIR_W=2, SUM_W=2.
  - typedef sw_pair_t logic[1:0] and sum_t logic[1:0].
  - function sw_sum(sw_pair_t) returning sum_t.
- Sub-module rr_arbiter (parameter N): inputs req, enable, ptr; outputs one-hot gnt and gnt_idx. It is purely combinational; rr_ptr stays in the top.
- The top holds rr_ptr, the response register and the handshake logic.

Test Plan:
- Reset check: assert i_rst_n=0 with random inputs -> o_rsp_valid=0, o_rsp_data=0, o_rsp_id=0, o_req_ready=0 after release with no valid.
- Single request: i_req_valid=4'b0100, data[5:4]=2'b11, i_rsp_ready=1 -> o_req_ready=4'b0100 in cycle t; o_rsp_valid=1, o_rsp_data=2, o_rsp_id=2 at t+1.
- Round-robin: all valid, pairs 00,01,10,11, rsp_ready=1 for 8 cycles -> ids 0,1,2,3,0,1,2,3; data 0,1,1,2 repeating; no idle cycles.
- Backpressure: response FULL (id 1, data 1) with i_rsp_ready=0 for 5 cycles -> outputs frozen and o_req_ready=0. Raise ready -> same cycle grants the next requester, with back-to-back valid and no bubble.
- Reset mid-operation: assert reset while o_rsp_valid=1 and rr_ptr=3 -> valid drops immediately. After release, the first grant among all-valid requesters is id 0.
- Withdrawn request: requester 3 pulses valid for 1 cycle while the slot is FULL and blocked -> no response with id 3 is ever produced, and rr_ptr is unchanged.
